// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the fetch port and the
// load/store port, steering each read response back to the port that issued it.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_t      r_rdOwner;
  owner_t      w_rdOwnerNext;
  logic [7:0]  r_starveCnt;
  logic [7:0]  w_starveCntNext;
  logic        w_ifGnt;
  logic        w_dGnt;
  logic        w_unusedBits;

  assign w_unusedBits = ^{if_addr[1:0], d_addr[1:0]};

  // Data wins ties unless the fetch has already lost STARVE_LIMIT arbitrations in a row.
  always_comb begin
    w_ifGnt = 1'b0;
    w_dGnt  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || (r_starveCnt == LIMIT))) begin
        w_ifGnt = 1'b1;
      end else if (d_req) begin
        w_dGnt = 1'b1;
      end
    end
  end

  assign if_gnt = w_ifGnt;
  assign d_gnt  = w_dGnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (w_ifGnt) begin
      mem_en   = 1'b1;
      mem_be   = 4'hF;
      mem_addr = if_addr[ADDR_W-1:2];
    end else if (w_dGnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'hF;
      mem_addr  = d_addr[ADDR_W-1:2];
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    w_rdOwnerNext = OWN_NONE;
    if (w_ifGnt) begin
      w_rdOwnerNext = OWN_IF;
    end else if (w_dGnt && !d_we) begin
      w_rdOwnerNext = OWN_D;
    end

    w_starveCntNext = r_starveCnt;
    if (!if_req || w_ifGnt) begin
      w_starveCntNext = 8'd0;
    end else if (w_dGnt && (r_starveCnt < LIMIT)) begin
      w_starveCntNext = r_starveCnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdOwner   <= OWN_NONE;
      r_starveCnt <= 8'd0;
    end else begin
      r_rdOwner   <= w_rdOwnerNext;
      r_starveCnt <= w_starveCntNext;
    end
  end

  // Gating with reset drops a response whose read was granted just before reset rose.
  assign if_rvalid = !reset && (r_rdOwner == OWN_IF);
  assign d_rvalid  = !reset && (r_rdOwner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters, a memory macro model and a scoreboard that
// predicts grants, memory drive and per-port read responses.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LIMIT  = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [3:0]        d_be = 4'h0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [31:0]       d_wdata = 32'h0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  bit                ifPend = 0;
  logic [ADDR_W-1:0] ifAddr;
  bit                dPend = 0;
  bit                dWe;
  logic [3:0]        dBe;
  logic [ADDR_W-1:0] dAddr;
  logic [31:0]       dWdata;
  int                ifLosses = 0;
  logic [31:0]       refMem [256];
  rsp_t              ifQ[$];
  rsp_t              dQ[$];

  logic [31:0]       memArray [256];
  bit                memLoaded = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seedWord(input int idx);
    return (idx * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  // Synchronous-read memory macro; loads its seed image on the first clock.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) memArray[i] <= seedWord(i);
      mem_rdata <= 32'h0;
      memLoaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) memArray[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= memArray[mem_addr[7:0]];
      end
    end
  end

  task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requester behaviour just after the rising edge, then check at the falling edge.
  task automatic applyStimulus(input int pIf, input int pD, input bit doReset);
    @(posedge clk);
    #1;
    reset = doReset;
    if (doReset) begin
      ifQ.delete();
      dQ.delete();
    end
    if (!ifPend && ($urandom_range(99) < pIf)) begin
      ifPend = 1;
      ifAddr = $urandom;
    end
    if (!dPend && ($urandom_range(99) < pD)) begin
      dPend  = 1;
      dWe    = 1'($urandom_range(1));
      dBe    = 4'($urandom);
      dAddr  = $urandom;
      dWdata = $urandom;
    end
    if_req  = ifPend;
    if_addr = ifPend ? ifAddr : $urandom;
    d_req   = dPend;
    d_we    = dPend ? dWe : 1'($urandom_range(1));
    d_be    = dPend ? dBe : 4'($urandom);
    d_addr  = dPend ? dAddr : $urandom;
    d_wdata = dPend ? dWdata : $urandom;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkOutput();
    bit   expIf = 0;
    bit   expD  = 0;
    int   idx;
    if (!reset) begin
      if (ifPend && (!dPend || ifLosses >= LIMIT)) expIf = 1;
      else if (dPend) expD = 1;
    end
    compareValue("if_gnt", 64'(if_gnt), 64'(expIf));
    compareValue("d_gnt", 64'(d_gnt), 64'(expD));
    compareValue("mem_en", 64'(mem_en), 64'(expIf | expD));
    if (expIf) begin
      compareValue("mem_we", 64'(mem_we), 64'd0);
      compareValue("mem_be", 64'(mem_be), 64'hF);
      compareValue("mem_addr", 64'(mem_addr), 64'(ifAddr >> 2));
    end else if (expD) begin
      compareValue("mem_we", 64'(mem_we), 64'(dWe));
      compareValue("mem_be", 64'(mem_be), dWe ? 64'(dBe) : 64'hF);
      compareValue("mem_addr", 64'(mem_addr), 64'(dAddr >> 2));
      compareValue("mem_wdata", 64'(mem_wdata), 64'(dWdata));
    end else begin
      compareValue("idle_mem_drive", {26'd0, mem_we, mem_be, mem_addr}, 64'd0);
      compareValue("idle_mem_wdata", 64'(mem_wdata), 64'd0);
    end

    if (reset || !ifPend || expIf) ifLosses = 0;
    else if (expD && ifLosses < LIMIT) ifLosses++;

    if (expIf) begin
      idx = int'(ifAddr[9:2]);
      ifQ.push_back('{due: cyc + 1, data: refMem[idx]});
      ifPend = 0;
    end
    if (expD) begin
      idx = int'(dAddr[9:2]);
      if (dWe) begin
        for (int b = 0; b < 4; b++)
          if (dBe[b]) refMem[idx][8*b +: 8] = dWdata[8*b +: 8];
      end else begin
        dQ.push_back('{due: cyc + 1, data: refMem[idx]});
      end
      dPend = 0;
    end
  endtask

  // Response monitor: a port must present exactly the responses that are due this cycle.
  initial begin
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (ifQ.size() > 0 && ifQ[0].due == cyc) begin
        exp = ifQ.pop_front();
        compareValue("if_rvalid", 64'(if_rvalid), 64'd1);
        compareValue("if_rdata", 64'(if_rdata), 64'(exp.data));
      end else begin
        compareValue("if_rvalid_idle", 64'(if_rvalid), 64'd0);
        compareValue("if_rdata_idle", 64'(if_rdata), 64'd0);
      end
      if (dQ.size() > 0 && dQ[0].due == cyc) begin
        exp = dQ.pop_front();
        compareValue("d_rvalid", 64'(d_rvalid), 64'd1);
        compareValue("d_rdata", 64'(d_rdata), 64'(exp.data));
      end else begin
        compareValue("d_rvalid_idle", 64'(d_rvalid), 64'd0);
        compareValue("d_rdata_idle", 64'(d_rdata), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);

    for (int i = 0; i < 3; i++) applyStimulus(100, 100, 1'b1);
    ifPend = 0;
    dPend  = 0;
    applyStimulus(0, 0, 1'b0);

    ifPend = 1; ifAddr = 32'h0000_0100;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    dPend = 1; dWe = 1; dBe = 4'b0011; dAddr = 32'h0000_0204; dWdata = 32'hDEADBEEF;
    applyStimulus(0, 0, 1'b0);
    dPend = 1; dWe = 0; dBe = 4'h0; dAddr = 32'h0000_0204; dWdata = 32'h0;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    ifPend = 1; ifAddr = 32'h0;
    applyStimulus(0, 0, 1'b0);
    dPend = 1; dWe = 0; dAddr = 32'h0000_0400;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    for (int i = 0; i < 12; i++) applyStimulus(100, 100, 1'b0);

    dPend = 1; dWe = 0; dAddr = 32'h0000_0010;
    ifPend = 1; ifAddr = 32'h0000_0020;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    for (int i = 0; i < 600; i++)
      applyStimulus(60, 60, ($urandom_range(99) < 3));
    for (int i = 0; i < 300; i++)
      applyStimulus(90, 90, 1'b0);
    ifPend = 0;
    dPend  = 0;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares the single-ported unified program/data memory between the core's instruction-fetch port and its load/store data port. It grants at most one access per cycle, drives the memory port, and steers each read response back to the port that issued it. Data accesses win by default; an anti-starvation counter guarantees fetch progress. It sits between the core's fetch/LSU request ports and the synchronous-read unified memory macro.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requester ports; memory word address is ADDR_W-2 bits.
- STARVE_LIMIT, 4, consecutive lost arbitrations a pending fetch tolerates before it is forced through (legal range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; if_addr held stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; d_* held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  ADDR_W  data byte address; bits [1:0] ignored
- d_wdata  in  32  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W-2  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after a read strobe

## Operation
- Grant (combinational from requests and registered state): only one req → grant it. Both → grant data unless starve_cnt == STARVE_LIMIT, then grant fetch. reset=1 forces both gnt = 0 and mem_en = 0.
- Memory drive: mem_en = if_gnt | d_gnt; mem_addr = granted addr[ADDR_W-1:2]; fetch grant → mem_we = 0, mem_be = 4'hF; data grant → mem_we = d_we, mem_be = d_we ? d_be : 4'hF, mem_wdata = d_wdata. mem_en = 0 → mem_we = 0, mem_be = 0, mem_addr/mem_wdata = 0.
- Response tracking: registered rd_owner ∈ {NONE, IF, D}. Each cycle: fetch grant → IF; data load grant → D; data store grant or no grant → NONE.
- if_rvalid = (rd_owner == IF); d_rvalid = (rd_owner == D). rdata = mem_rdata when its rvalid = 1, else 0.
- Stores complete at d_gnt; they produce no rvalid.
- Starvation counter starve_cnt (8 bits, saturating at STARVE_LIMIT): increments when if_req = 1 and d_gnt = 1; clears when if_gnt = 1 or if_req = 0.

## Timing
- Reset values: rd_owner = NONE, starve_cnt = 0; hence if_rvalid = d_rvalid = 0 and both rdata = 0 in the cycle after reset. gnt/mem_* are 0 while reset is high.
- Grant latency 0 cycles (same cycle as req). Read latency: rvalid exactly 1 cycle after gnt. Fully pipelined: one new grant every cycle; response for cycle N overlaps grant for cycle N+1.
- Requester may drop or change req only after gnt; a req dropped before gnt has no effect on memory.
- Worst-case fetch wait with continuous data traffic: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1.
- Reset mid-operation: a read granted in cycle N with reset high in cycle N+1 returns no rvalid in N+1 or later; starve_cnt cleared.
- Back-to-back reads to different ports: response steering follows rd_owner exactly; no response is lost or duplicated.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x100 → if_gnt same cycle, mem_en = 1, mem_addr = 0x40, mem_we = 0; next cycle if_rvalid = 1, if_rdata = mem_rdata (e.g. 0x00500093).
- Contention, STARVE_LIMIT = 4, both req held high: d_gnt cycles 1-4, if_gnt cycle 5, d_gnt cycles 6-9, if_gnt cycle 10.
- Store: d_req = 1, d_we = 1, d_be = 4'b0011, d_addr = 0x204, d_wdata = 0xDEADBEEF → mem_we = 1, mem_be = 0011, mem_addr = 0x81, mem_wdata = 0xDEADBEEF; next cycle d_rvalid = 0, if_rvalid = 0.
- Interleave: fetch read 0x0 at cycle N, data load 0x400 at N+1 → if_rvalid only at N+1, d_rvalid only at N+2, each carrying that cycle's mem_rdata.
- Counter clear: both req for 3 cycles (starve_cnt = 3), if_req low 1 cycle, then both high → data wins 4 more cycles before fetch.
- Reset mid-read: load granted cycle N, reset = 1 at N+1 → d_rvalid = 0 at N+1 and N+2, starve_cnt = 0, no gnt while reset high.
